// File: rtl/acquisition_control.sv
// Ring-buffer acquisition controller: pre-trigger fill, arming, post-trigger capture,
// then oldest-first readout of the DEPTH-sample window over a valid/ready port.
module acquisition_control #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pretrigger_len,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  triggered,
  output logic                  trigger_enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  data_last,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   POST_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_PENULT = ADDR_WIDTH'(DEPTH - 2);

  typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST, READOUT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   post_q, post_d, post_load;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  busy_q, te_q;
  logic                  wr_en, hs, enter_readout;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    wr_en         = sample_valid && (state_q == PRE_FILL || state_q == ARMED || state_q == POST);
    wr_ptr_d      = wr_ptr_q + ADDR_WIDTH'(wr_en);
    hs            = valid_q && data_ready;
    post_load     = DEPTH_C - {1'b0, pre_q};
    enter_readout = 1'b0;
    state_d       = state_q;
    pre_d         = pre_q;
    count_d       = count_q;
    post_d        = post_q;
    rd_ptr_d      = rd_ptr_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    last_d        = last_q;
    done_d        = 1'b0;

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = PRE_FILL;
            pre_d   = pretrigger_len;
            count_d = '0;
          end
        end
        PRE_FILL: begin
          if (pre_q == '0) begin
            state_d = ARMED;
          end else if (wr_en) begin
            count_d = count_q + ADDR_ONE;
            if (count_q + ADDR_ONE == pre_q) state_d = ARMED;
          end
        end
        ARMED: begin
          // A sample arriving with the trigger is already the first post-trigger sample.
          if (triggered) begin
            post_d = sample_valid ? post_load - POST_ONE : post_load;
            if (sample_valid && post_load == POST_ONE) enter_readout = 1'b1;
            else state_d = POST;
          end
        end
        POST: begin
          if (wr_en) begin
            post_d = post_q - POST_ONE;
            if (post_q == POST_ONE) enter_readout = 1'b1;
          end
        end
        READOUT: begin
          if (hs) begin
            if (last_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + ADDR_ONE;
              idx_d    = idx_q + ADDR_ONE;
              last_d   = (idx_q == IDX_PENULT);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // The slot after the final write is the oldest sample of the window.
      if (enter_readout) begin
        state_d  = READOUT;
        rd_ptr_d = wr_ptr_d;
        idx_d    = '0;
        valid_d  = 1'b1;
        last_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      count_q  <= '0;
      post_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      te_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      count_q  <= count_d;
      post_q   <= post_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
      te_q     <= (state_d == ARMED);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
  end

  // Reading at the next pointer keeps rdata_q equal to the presented sample, so a
  // stall holds data_out and an accepted beat is replaced on the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem[rd_ptr_d];
  end

  assign trigger_enable = te_q;
  assign busy           = busy_q;
  assign data_out       = rdata_q;
  assign data_valid     = valid_q;
  assign data_last      = last_q;
  assign done           = done_q;

endmodule

// File: tb/tb_acquisition_control.sv
// Testbench for acquisition_control: directed captures checked every cycle against a
// queue-based window model, plus literal expectations for the documented scenarios.
module tb_acquisition_control;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pretrigger_len = '0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          triggered = 1'b0;
  logic          trigger_enable;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b1;
  logic          data_last;
  logic          done;

  acquisition_control #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pretrigger_len(pretrigger_len), .sample_in(sample_in),
    .sample_valid(sample_valid), .triggered(triggered),
    .trigger_enable(trigger_enable), .busy(busy), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .data_last(data_last),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model: phases named after the behaviour, window = last DEPTH samples written.
  typedef enum {M_IDLE, M_FILL, M_ARMED, M_POST, M_READ} mphase_t;
  mphase_t mPhase = M_IDLE;
  int  mPre = 0, mCount = 0, mPostLeft = 0, mReadCycles = 0;
  bit  mDone = 0, mHsSeen = 0, prevStall = 0, doneSeen = 0;
  int  prevData = 0, prevLast = 0, cycleNo = 0;
  int  hist[$], window[$], gotVals[$], hsCycle[$];
  bit  enterRead;

  always @(negedge clk) begin
    cycleNo++;
    if (reset) begin
      checkOutput("resetOutputsLow", int'({busy, trigger_enable, data_valid, done, data_last}), 0);
      mPhase = M_IDLE; mDone = 0; prevStall = 0;
      hist.delete(); window.delete();
    end else begin
      checkOutput("busy", int'(busy), int'(mPhase != M_IDLE));
      checkOutput("triggerEnable", int'(trigger_enable), int'(mPhase == M_ARMED));
      checkOutput("done", int'(done), int'(mDone));
      if (done) doneSeen = 1;
      if (mPhase != M_READ) checkOutput("validOutsideReadout", int'(data_valid), 0);
      else if (mReadCycles == 1 && !mHsSeen) checkOutput("validRiseLatency", int'(data_valid), 1);
      if (prevStall) begin
        checkOutput("holdValid", int'(data_valid), 1);
        checkOutput("holdData", int'(data_out), prevData);
        checkOutput("holdLast", int'(data_last), prevLast);
      end
      if (data_valid && mPhase == M_READ)
        checkOutput("lastFlag", int'(data_last), int'(window.size() == 1));
      prevStall = data_valid && !data_ready && !abort && mPhase == M_READ;
      prevData  = int'(data_out);
      prevLast  = int'(data_last);

      mDone = 0;
      enterRead = 0;
      if (mPhase == M_READ) mReadCycles++;
      if (sample_valid && (mPhase == M_FILL || mPhase == M_ARMED || mPhase == M_POST)) begin
        hist.push_back(int'(sample_in));
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      if (abort) begin
        mPhase = M_IDLE;
      end else begin
        case (mPhase)
          M_IDLE: if (start) begin
            mPhase = M_FILL; mPre = int'(pretrigger_len); mCount = 0;
          end
          M_FILL: begin
            if (mPre == 0) mPhase = M_ARMED;
            else if (sample_valid) begin
              mCount++;
              if (mCount == mPre) mPhase = M_ARMED;
            end
          end
          M_ARMED: if (triggered) begin
            mPostLeft = DEPTH - mPre - (sample_valid ? 1 : 0);
            if (mPostLeft == 0) enterRead = 1; else mPhase = M_POST;
          end
          M_POST: if (sample_valid) begin
            mPostLeft--;
            if (mPostLeft == 0) enterRead = 1;
          end
          M_READ: if (data_valid && data_ready) begin
            mHsSeen = 1;
            if (window.size() == 0) checkOutput("unexpectedTransfer", 1, 0);
            else begin
              checkOutput("readoutData", int'(data_out), window[0]);
              gotVals.push_back(int'(data_out));
              hsCycle.push_back(cycleNo);
              void'(window.pop_front());
              if (window.size() == 0) begin
                mPhase = M_IDLE; mDone = 1;
              end
            end
          end
          default: mPhase = M_IDLE;
        endcase
        if (enterRead) begin
          window = hist; mPhase = M_READ; mReadCycles = 0; mHsSeen = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input bit st, input bit ab, input int ptl, input bit sv,
                               input int sd, input bit tr, input bit rdy);
    start = st; abort = ab; pretrigger_len = AW'(ptl);
    sample_valid = sv; sample_in = DW'(sd); triggered = tr; data_ready = rdy;
    @(posedge clk); #2;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic runRamp(input int pre, input int trigA, input int trigB, input int lastVal);
    applyStimulus(1, 0, pre, 0, 0, 0, 1);
    for (int v = 0; v <= lastVal; v++)
      applyStimulus(0, 0, 0, 1, v, (v == trigA) || (v == trigB), 1);
  endtask

  task automatic drainReadout(input bit alternate, input int stopAfter);
    doneSeen = 0;
    for (int i = 0; i < 300 && !doneSeen && (stopAfter == 0 || gotVals.size() < stopAfter); i++)
      applyStimulus(0, 0, 0, 0, 0, 0, alternate ? (i % 2 == 0) : 1'b1);
    if (stopAfter == 0 && !doneSeen) checkOutput("readoutTimeout", 0, 1);
  endtask

  task automatic checkWindow(input string name, input int first);
    checkOutput({name, "Count"}, gotVals.size(), DEPTH);
    for (int i = 0; i < gotVals.size() && i < DEPTH; i++)
      checkOutput(name, gotVals[i], first + i);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #1 checkOutput("powerOnReset", int'({busy, trigger_enable, data_valid, done, data_last}), 0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    idleCycle();

    // Case 1: pre=4, trigger on sample 20, window 16..31 at one beat per cycle.
    gotVals.delete(); hsCycle.delete();
    runRamp(4, 20, -1, 31);
    drainReadout(0, 0);
    checkWindow("case1", 16);
    if (hsCycle.size() == DEPTH) checkOutput("case1Span", hsCycle[DEPTH-1] - hsCycle[0], DEPTH - 1);
    checkOutput("case1BusyAfter", int'(busy), 0);
    idleCycle();

    // Case 2: pre=0 arms one cycle after start; trigger on first armed sample.
    gotVals.delete();
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("case2TeInFill", int'(trigger_enable), 0);
    idleCycle();
    checkOutput("case2TeArmed", int'(trigger_enable), 1);
    for (int v = 0; v < DEPTH; v++) applyStimulus(0, 0, 0, 1, v, v == 0, 1);
    drainReadout(0, 0);
    checkWindow("case2", 0);
    idleCycle();

    // Case 3: pre=8, trigger during fill ignored, later trigger at 12 -> window 4..19.
    gotVals.delete();
    applyStimulus(1, 0, 8, 0, 0, 0, 1);
    for (int v = 0; v <= 19; v++) begin
      applyStimulus(0, 0, 0, 1, v, (v == 2) || (v == 12), 1);
      if (v == 6) checkOutput("case3TeBeforeFull", int'(trigger_enable), 0);
      if (v == 7) checkOutput("case3TeAfterFull", int'(trigger_enable), 1);
    end
    drainReadout(0, 0);
    checkWindow("case3", 4);
    idleCycle();

    // Case 4: case 1 with alternating ready.
    gotVals.delete();
    runRamp(4, 20, -1, 31);
    drainReadout(1, 0);
    checkWindow("case4", 16);
    idleCycle();

    // Case 5: abort after three post-trigger samples, then a clean rerun.
    gotVals.delete();
    runRamp(4, 20, -1, 22);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("case5BusyAfterAbort", int'(busy), 0);
    checkOutput("case5DoneAfterAbort", int'(done), 0);
    checkOutput("case5TeAfterAbort", int'(trigger_enable), 0);
    idleCycle();
    checkOutput("case5NoLateDone", int'(done), 0);
    gotVals.delete();
    runRamp(4, 20, -1, 31);
    drainReadout(0, 0);
    checkWindow("case5Rerun", 16);
    idleCycle();

    // Case 6: asynchronous reset mid-readout, then a clean rerun.
    gotVals.delete();
    runRamp(4, 20, -1, 31);
    drainReadout(0, 5);
    #1 reset = 1'b1;
    #1;
    checkOutput("case6ValidAsync", int'(data_valid), 0);
    checkOutput("case6BusyAsync", int'(busy), 0);
    checkOutput("case6DoneAsync", int'(done), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    idleCycle();
    gotVals.delete();
    runRamp(4, 20, -1, 31);
    drainReadout(0, 0);
    checkWindow("case6Rerun", 16);
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
